rns_forward_converter: RTL and testbench



---
 rtl/rns_pkg.sv | 25 ++
 rtl/rns_mod_lane.sv | 65 ++++++
 rtl/rns_forward_converter.sv | 142 ++++++++++++++
 tb/tb_rns_forward_converter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared RNS definitions: default geometry, converter state encoding and the
// lane slicing helper used by both the forward converter and the CRT block.
package rns_pkg;

  localparam int unsigned DEF_NUM_MODULI = 4;
  localparam int unsigned DEF_MOD_WIDTH  = 4;
  localparam int unsigned DEF_X_WIDTH    = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REDUCE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    REDUCE = ST_REDUCE,
    DONE   = ST_DONE
  } conv_state_e;

  // LSB position of residue/modulus lane `lane` in a packed lane vector.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/rns_mod_lane.sv
// One residue lane of the forward converter: holds the captured modulus and
// the running remainder, and folds in one x bit per step with a single
// conditional subtract (r stays below m, so one subtract always suffices).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load, m_in        capture modulus
//   clear             zero the remainder
//   step, bit_in      advance one bit: r = 2r + b, minus m if that reaches m
//   residue_c         remainder, forced to 0 for a zero modulus
//   zero_mod_c        captured modulus is 0
module rns_mod_lane
  import rns_pkg::*;
#(
  parameter int unsigned MOD_WIDTH = DEF_MOD_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [MOD_WIDTH-1:0] m_in,
  input  logic                 clear,
  input  logic                 step,
  input  logic                 bit_in,
  output logic [MOD_WIDTH-1:0] residue_c,
  output logic                 zero_mod_c
);

  logic [MOD_WIDTH-1:0] m_q, m_d;
  logic [MOD_WIDTH-1:0] r_q, r_d;
  logic [MOD_WIDTH:0]   t_c;
  logic [MOD_WIDTH:0]   m_ext_c;

  assign zero_mod_c = (m_q == '0);
  assign residue_c  = zero_mod_c ? '0 : r_q;

  // Next remainder; a zero-modulus lane simply holds its cleared value.
  always_comb begin
    m_d     = m_q;
    r_d     = r_q;
    t_c     = {r_q, bit_in};
    m_ext_c = {1'b0, m_q};
    if (load) begin
      m_d = m_in;
    end
    if (clear) begin
      r_d = '0;
    end else if (step && !zero_mod_c) begin
      if (t_c >= m_ext_c) begin
        r_d = MOD_WIDTH'(t_c - m_ext_c);
      end else begin
        r_d = t_c[MOD_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      r_q <= '0;
    end else begin
      m_q <= m_d;
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/rns_forward_converter.sv
// Forward RNS converter: bit-serial restoring reduction of x against every
// modulus lane in parallel, MSB first, behind valid/ready handshakes.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_ready       operand handshake (x_in, m_in sampled on accept)
//   x_in                    unsigned integer to decompose
//   m_in                    packed moduli, lane 0 in the LSBs
//   out_valid/out_ready     result handshake
//   residues                packed x mod m_i, same lane order as m_in
//   err_zero_mod            per-lane flag, captured modulus was 0
module rns_forward_converter
  import rns_pkg::*;
#(
  parameter int unsigned NUM_MODULI = DEF_NUM_MODULI,
  parameter int unsigned MOD_WIDTH  = DEF_MOD_WIDTH,
  parameter int unsigned X_WIDTH    = DEF_X_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [X_WIDTH-1:0]              x_in,
  input  logic [NUM_MODULI*MOD_WIDTH-1:0] m_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_MODULI*MOD_WIDTH-1:0] residues,
  output logic [NUM_MODULI-1:0]           err_zero_mod
);

  localparam int unsigned CNT_WIDTH = $clog2(X_WIDTH + 1);
  localparam int unsigned RES_WIDTH = NUM_MODULI * MOD_WIDTH;

  conv_state_e            state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [RES_WIDTH-1:0]   residues_q, residues_d;
  logic [NUM_MODULI-1:0]  err_q, err_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [X_WIDTH-1:0]     x_q, x_d;

  logic                   lane_load_c;
  logic                   lane_step_c;
  logic [RES_WIDTH-1:0]   lane_res_c;
  logic [NUM_MODULI-1:0]  lane_zero_c;

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign residues     = residues_q;
  assign err_zero_mod = err_q;

  for (genvar i = 0; i < NUM_MODULI; i++) begin : g_lane
    rns_mod_lane #(
      .MOD_WIDTH (MOD_WIDTH)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .load       (lane_load_c),
      .m_in       (m_in[lane_lsb(i, MOD_WIDTH) +: MOD_WIDTH]),
      .clear      (lane_load_c),
      .step       (lane_step_c),
      .bit_in     (x_q[X_WIDTH-1]),
      .residue_c  (lane_res_c[lane_lsb(i, MOD_WIDTH) +: MOD_WIDTH]),
      .zero_mod_c (lane_zero_c[i])
    );
  end

  // Next-state and registered-output logic. REDUCE spends X_WIDTH cycles
  // stepping, then one more cycle latching the lane results into DONE.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    residues_d  = residues_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    lane_load_c = 1'b0;
    lane_step_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid && in_ready_q) begin
          x_d         = x_in;
          cnt_d       = '0;
          lane_load_c = 1'b1;
          in_ready_d  = 1'b0;
          state_d     = REDUCE;
        end
      end
      REDUCE: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        if (cnt_q == CNT_WIDTH'(X_WIDTH)) begin
          residues_d  = lane_res_c;
          err_d       = lane_zero_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          lane_step_c = 1'b1;
          x_d         = {x_q[X_WIDTH-2:0], 1'b0};
          cnt_d       = cnt_q + CNT_WIDTH'(1);
        end
      end
      DONE: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      residues_q  <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      residues_q  <= residues_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
    end
  end

endmodule

// File: tb/tb_rns_forward_converter.sv
// Self-checking bench for rns_forward_converter: a driver pushes expected
// results into a scoreboard queue, a monitor pops and compares on each
// accepted output beat.
module tb_rns_forward_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in;
  logic [15:0] m_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] residues;
  logic [3:0]  err_zero_mod;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  err;
    logic [15:0] x;
    bit          crt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rns_forward_converter dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x_in         (x_in),
    .m_in         (m_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .residues     (residues),
    .err_zero_mod (err_zero_mod)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRT reconstruction for moduli {11,9,7,4} by exhaustive search over 0..2771.
  function automatic int crt_reconstruct(input logic [15:0] r);
    for (int y = 0; y < 2772; y++) begin
      if ((y % 4) == int'(r[3:0]) && (y % 7) == int'(r[7:4]) &&
          (y % 9) == int'(r[11:8]) && (y % 11) == int'(r[15:12]))
        return y;
    end
    return -1;
  endfunction

  // Monitor: compare every accepted output beat against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got residues %0h expected no output", residues);
        end else begin
          e = sb.pop_front();
          check("residues", 32'(residues), 32'(e.res));
          check("err_zero_mod", 32'(err_zero_mod), 32'(e.err));
          if (e.crt)
            check("crt_loopback", 32'(crt_reconstruct(residues)), 32'(e.x) % 32'd2772);
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    ok = in_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  // Issue one conversion and wait for out_valid; inputs are scrambled after
  // the accept edge since they must be ignored from then on.
  task automatic convert(input logic [15:0] x, input logic [15:0] m,
                         input logic [15:0] er, input logic [3:0] ee,
                         input bit crt, input bit chk_lat);
    bit ok;
    int k;
    wait_ready(ok);
    if (!ok) return;
    x_in     = x;
    m_in     = m;
    in_valid = 1'b1;
    sb.push_back('{er, ee, x, crt});
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = 16'($urandom);
    m_in     = 16'($urandom);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!out_valid && k < 40);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1 after %0d cycles", k);
    end else if (chk_lat) begin
      check("latency", 32'(k), 32'd17);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] x;
    logic [15:0] er;
    bit          ok;
    int          k;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    m_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_residues", 32'(residues), 32'd0);
    check("reset_err", 32'(err_zero_mod), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, moduli {11,9,7,4} packed as 16'hB974.
    convert(16'd1243, 16'hB974, 16'h0143, 4'b0000, 1'b0, 1'b1);
    convert(16'hFFFF, 16'hB974, 16'h8613, 4'b0000, 1'b0, 1'b0);
    convert(16'h0000, 16'hB974, 16'h0000, 4'b0000, 1'b0, 1'b0);
    convert(16'd1243, 16'hB074, 16'h0043, 4'b0100, 1'b0, 1'b0);
    convert(16'd1243, 16'h1111, 16'h0000, 4'b0000, 1'b0, 1'b0);

    // Backpressure: result frozen and in_ready low while out_ready is low.
    out_ready = 1'b0;
    convert(16'd1243, 16'hB974, 16'h0143, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_residues", 32'(residues), 32'h0143);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset mid-REDUCE aborts with no output; the next conversion is clean.
    wait_ready(ok);
    if (ok) begin
      x_in     = 16'd1243;
      m_in     = 16'hB974;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_residues", 32'(residues), 32'd0);
      check("abort_err", 32'(err_zero_mod), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
    end
    convert(16'd1243, 16'hB974, 16'h0143, 4'b0000, 1'b0, 1'b1);

    // Loopback through a CRT reconstruction across random operands.
    for (int n = 0; n < 200; n++) begin
      x  = 16'($urandom_range(0, 65535));
      er = {4'(x % 16'd11), 4'(x % 16'd9), 4'(x % 16'd7), 4'(x % 16'd4)};
      convert(x, 16'hB974, er, 4'b0000, 1'b1, 1'b0);
    end

    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
